// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback beats a small multdiv result FIFO.
// Optional stall counter enabled by macro WB_ARBITER_STALL_CNT_EN.
module wb_arbiter #(
  parameter int         DEPTH      = 2,
  parameter logic [4:0] STATUS_REG = 5'd30
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  input  logic        md_exception,
  input  logic [31:0] md_status,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  input  logic [4:0]  hz_reg,
  output logic        hz_pending,
  output logic [15:0] stall_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [4:0]       ent_reg_q [DEPTH];
  logic [31:0]      ent_dat_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      wdat_q, wdat_d;

  logic        md_acc, md_live, buf_nonempty, pop, push;
  logic [4:0]  md_dst;
  logic [31:0] md_val;

  assign md_ready     = (cnt_q < DEPTH_C);
  assign md_acc       = md_valid && md_ready;
  assign md_dst       = md_exception ? STATUS_REG : md_reg;
  assign md_val       = md_exception ? md_status : md_data;
  assign md_live      = md_acc && (md_dst != 5'd0);
  assign buf_nonempty = (cnt_q != '0);
  assign pop          = !wb_valid && buf_nonempty;
  assign push         = md_live && (wb_valid || buf_nonempty);

  always_comb begin
    we_d   = 1'b0;
    wreg_d = wreg_q;
    wdat_d = wdat_q;
    live_d = live_q;
    if (wb_valid) begin
      if (wb_reg != 5'd0) begin
        we_d   = 1'b1;
        wreg_d = wb_reg;
        wdat_d = wb_data;
        // Older buffered writes to the same register must never land.
        for (int i = 0; i < DEPTH; i++) begin
          if (live_q[i] && (ent_reg_q[i] == wb_reg)) live_d[i] = 1'b0;
        end
      end
    end else if (pop) begin
      if (live_q[rd_ptr_q]) begin
        we_d   = 1'b1;
        wreg_d = ent_reg_q[rd_ptr_q];
        wdat_d = ent_dat_q[rd_ptr_q];
      end
      live_d[rd_ptr_q] = 1'b0;
    end else if (md_live) begin
      we_d   = 1'b1;
      wreg_d = md_dst;
      wdat_d = md_val;
    end
    if (push) live_d[wr_ptr_q] = 1'b1;

    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      live_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      wreg_q   <= 5'd0;
      wdat_q   <= 32'd0;
    end else begin
      live_q   <= live_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdat_q   <= wdat_d;
    end
  end

  // Payload storage needs no reset; live bits alone decide validity.
  always_ff @(posedge clock) begin
    if (push) begin
      ent_reg_q[wr_ptr_q] <= md_dst;
      ent_dat_q[wr_ptr_q] <= md_val;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdat_q;

  always_comb begin
    hz_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (ent_reg_q[i] == hz_reg)) hz_pending = 1'b1;
    end
    if (hz_reg == 5'd0) hz_pending = 1'b0;
  end

`ifdef WB_ARBITER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      stall_q <= 16'h0;
    end else if (wb_valid && (|live_q) && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes queued as stimulus is driven, popped by a write monitor.
module tb_wb_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_exception;
  logic [31:0] md_status;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  hz_reg;
  logic        hz_pending;
  logic [15:0] stall_cnt;

  always #5 clock = ~clock;

  wb_arbiter dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
    .md_exception(md_exception), .md_status(md_status),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .hz_reg(hz_reg), .hz_pending(hz_pending), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

`ifdef WB_ARBITER_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  always @(negedge clock) begin
    if (ctrl_writeEnable === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got reg=%0d data=%h, required no write", ctrl_writeReg, data_writeReg);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({ctrl_writeReg, data_writeReg} !== {e.r, e.d}) begin
          n_fail++;
          $display("FAIL write_data: got reg=%0d data=%h, required reg=%0d data=%h",
                   ctrl_writeReg, data_writeReg, e.r, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    md_valid = 1'b0; md_reg = 5'd0; md_data = 32'd0;
    md_exception = 1'b0; md_status = 32'd0;
  endtask

  task automatic do_reset();
    idle();
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
  endtask

  task automatic push_exp(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.r = r; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: got %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    hz_reg = 5'd5;
    do_reset();
    n_tests++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_port: got we=%b reg=%0d data=%h, required all 0", ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    n_tests++;
    if ({md_ready, hz_pending, stall_cnt} !== {1'b1, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_status: got md_ready=%b hz=%b stall=%h, required 1 0 0000", md_ready, hz_pending, stall_cnt);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    md_valid = 1'b1; md_reg = 5'd5; md_data = 32'h1234;
    push_exp(5'd5, 32'h1234);
    tick();
    idle();
    n_tests++;
    if (ctrl_writeEnable !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_we: got %b, required 1", ctrl_writeEnable);
    end
    tick();
    n_tests++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b0, 5'd5, 32'h1234}) begin
      n_fail++;
      $display("FAIL bypass_hold: got we=%b reg=%0d data=%h, required 0 5 00001234", ctrl_writeEnable, ctrl_writeReg, data_writeReg);
    end
    check_drained("bypass");
  endtask

  task automatic test_buffer_full();
    do_reset();
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'hA1;
    md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h70;
    push_exp(5'd3, 32'hA1);
    tick();
    wb_data = 32'hA2; md_reg = 5'd8; md_data = 32'h80;
    push_exp(5'd3, 32'hA2);
    tick();
    n_tests++;
    if (md_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got %b, required 0", md_ready);
    end
    md_valid = 1'b0; wb_data = 32'hA3;
    push_exp(5'd3, 32'hA3);
    tick();
    idle();
    push_exp(5'd7, 32'h70);
    tick();
    n_tests++;
    if (md_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_ready: got %b, required 1", md_ready);
    end
    push_exp(5'd8, 32'h80);
    tick();
    n_tests++;
    if (stall_cnt !== (STALL_EN ? 16'd2 : 16'd0)) begin
      n_fail++;
      $display("FAIL stall_count: got %0d, required %0d", stall_cnt, STALL_EN ? 2 : 0);
    end
    tick();
    check_drained("full");
  endtask

  task automatic test_waw();
    do_reset();
    hz_reg = 5'd9;
    wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h44;
    md_valid = 1'b1; md_reg = 5'd9; md_data = 32'h55;
    push_exp(5'd4, 32'h44);
    tick();
    n_tests++;
    if (hz_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL waw_hz_set: got %b, required 1", hz_pending);
    end
    md_valid = 1'b0; wb_reg = 5'd9; wb_data = 32'hAA;
    push_exp(5'd9, 32'hAA);
    tick();
    idle();
    n_tests++;
    if (hz_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL waw_hz_clr: got %b, required 0", hz_pending);
    end
    tick();
    n_tests++;
    if (ctrl_writeEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL waw_killed_pop: got we=%b, required 0", ctrl_writeEnable);
    end
    tick();
    check_drained("waw");
  endtask

  task automatic test_exception();
    do_reset();
    md_valid = 1'b1; md_reg = 5'd12; md_data = 32'hDEAD;
    md_exception = 1'b1; md_status = 32'd4;
    push_exp(5'd30, 32'd4);
    tick();
    idle();
    tick();
    check_drained("exception");
  endtask

  task automatic test_reg_zero();
    do_reset();
    hz_reg = 5'd0;
    for (int i = 0; i < 2; i++) begin
      wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'hFF;
      md_valid = 1'b1; md_reg = 5'd0; md_data = 32'h11;
      tick();
      n_tests++;
      if ({ctrl_writeEnable, md_ready, hz_pending} !== 3'b010) begin
        n_fail++;
        $display("FAIL zero_drop: got we=%b md_ready=%b hz=%b, required 0 1 0", ctrl_writeEnable, md_ready, hz_pending);
      end
    end
    idle();
    md_valid = 1'b1;
    tick();
    idle();
    tick();
    n_tests++;
    if ((ctrl_writeEnable !== 1'b0) || (md_ready !== 1'b1)) begin
      n_fail++;
      $display("FAIL zero_after: got we=%b md_ready=%b, required 0 1", ctrl_writeEnable, md_ready);
    end
    check_drained("zero");
  endtask

  task automatic test_reset_mid();
    do_reset();
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h1;
    md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h70;
    push_exp(5'd3, 32'h1);
    tick();
    wb_data = 32'h2; md_reg = 5'd8; md_data = 32'h80;
    push_exp(5'd3, 32'h2);
    tick();
    n_tests++;
    if ((md_ready !== 1'b0) || (stall_cnt !== (STALL_EN ? 16'd1 : 16'd0))) begin
      n_fail++;
      $display("FAIL pre_reset: got md_ready=%b stall=%0d, required 0 %0d", md_ready, stall_cnt, STALL_EN ? 1 : 0);
    end
    do_reset();
    n_tests++;
    if ({ctrl_writeEnable, md_ready, stall_cnt} !== {1'b0, 1'b1, 16'h0}) begin
      n_fail++;
      $display("FAIL mid_reset: got we=%b md_ready=%b stall=%h, required 0 1 0000", ctrl_writeEnable, md_ready, stall_cnt);
    end
    tick();
    n_tests++;
    if (ctrl_writeEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_write: got we=%b, required 0", ctrl_writeEnable);
    end
    tick();
    check_drained("reset_mid");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      md_valid = 1'b1; md_reg = 5'(16 + i); md_data = d;
      push_exp(5'(16 + i), d);
      tick();
    end
    idle();
    tick();
    check_drained("b2b_bypass");

    wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'hC1;
    md_valid = 1'b1; md_reg = 5'd20; md_data = 32'hD1;
    push_exp(5'd2, 32'hC1);
    tick();
    wb_valid = 1'b0; md_reg = 5'd21; md_data = 32'hD2;
    push_exp(5'd20, 32'hD1);
    tick();
    idle();
    n_tests++;
    if (md_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pushpop_ready: got %b, required 1", md_ready);
    end
    push_exp(5'd21, 32'hD2);
    tick();
    tick();
    check_drained("b2b_pushpop");
  endtask

  initial begin
    ctrl_reset = 1'b0;
    hz_reg = 5'd0;
    idle();
    tick();
    test_reset();
    test_bypass();
    test_buffer_full();
    test_waw();
    test_exception();
    test_reg_zero();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, multdiv result buffer entries (power of two, 2..8).
REQ-002 SHALL have parameter STATUS_REG, default 5'd30, exception destination register.
REQ-003 SHALL use one clock; reset is synchronous and active-high. Ports: clock  in  1  rising-edge clock; ctrl_reset  in  1  synchronous active-high reset.
REQ-004 SHALL have ports wb_valid  in  1  pipeline writeback request; wb_reg  in  5  destination register; wb_data  in  32  write data.
REQ-005 SHALL have ports md_valid  in  1  multdiv result valid; md_ready  out  1  buffer can accept; md_reg  in  5  destination; md_data  in  32  result; md_exception  in  1  overflow or div-by-zero; md_status  in  32  rstatus code.
REQ-006 SHALL have ports ctrl_writeEnable  out  1; ctrl_writeReg  out  5; data_writeReg  out  32. These drive the register file write port.
REQ-007 SHALL have ports hz_reg  in  5  hazard query register; hz_pending  out  1  a live buffered write targets hz_reg.
REQ-008 SHALL have port stall_cnt  out  16  count of blocked-buffer cycles.

Function
REQ-009 SHALL register all write-port outputs; a request accepted in cycle N appears on ctrl_* in cycle N+1.
REQ-010 SHALL accept a multdiv result when md_valid && md_ready in the same cycle.
REQ-011 SHALL compute md_ready = (count < DEPTH) from registered count only; a pop in the same cycle does not raise md_ready.
REQ-012 SHALL redirect an accepted result with md_exception=1 to register STATUS_REG with data md_status.
REQ-013 SHALL drop any request targeting register 0: no write, no enqueue, accepted normally.
REQ-014 SHALL arbitrate each cycle with priority: wb_valid first. Otherwise the live buffer head. Otherwise an accepted multdiv result with an empty buffer, which bypasses straight to the port.
REQ-015 SHALL enqueue an accepted multdiv result whenever it does not win the port (wb_valid=1 or buffer non-empty).
REQ-016 SHALL, on wb_valid with wb_reg matching any live buffer entry's register, clear that entry's live bit in the same cycle (younger write wins, WAW).
REQ-017 SHALL, if the same-cycle accepted multdiv result matches wb_reg, still enqueue it live (multdiv is younger).
REQ-018 SHALL pop a killed head without asserting ctrl_writeEnable, consuming one cycle.
REQ-019 SHALL drive ctrl_writeEnable=0 in any cycle with no winning live request; ctrl_writeReg/data_writeReg then hold their last values.
REQ-020 SHALL make hz_pending combinational: 1 iff any live entry register equals hz_reg and hz_reg != 0.
REQ-021 SHALL make the buffer a circular FIFO with wrapping read/write pointers and a 0..DEPTH count; it supports simultaneous push and pop.

Reset
REQ-022 SHALL, on clock edge with ctrl_reset=1, clear count, pointers, all live bits, ctrl_writeEnable, ctrl_writeReg, data_writeReg and stall_cnt to 0.
REQ-023 SHALL discard buffered entries on reset mid-operation; no write issues in the cycle after reset.
REQ-024 SHALL hold md_ready=1 from the first cycle after reset.

Configuration
REQ-025 SHALL, with macro WB_ARBITER_STALL_CNT_EN defined, increment stall_cnt (saturating at 16'hFFFF) each cycle wb_valid=1 and the buffer holds a live entry.
REQ-026 SHALL, without WB_ARBITER_STALL_CNT_EN, tie stall_cnt to 16'h0 with no counter logic.

Verification
REQ-027 SHALL cover: md_valid, md_reg=5, md_data=32'h1234, buffer empty, wb_valid=0 -> next cycle we=1, reg=5, data=32'h1234.
REQ-028 SHALL cover: wb_valid=1 on reg 3 for 3 cycles, md results for regs 7 and 8 -> md_ready=0 after the second push; regs 7 and 8 write in order in the 2 cycles after wb_valid drops.
REQ-029 SHALL cover: md reg 9 buffered, then wb_valid reg 9 data 32'hAA -> reg 9 written with 32'hAA only; killed head pops with we=0; hz_pending(9) goes 1 then 0.
REQ-030 SHALL cover: md_exception=1, md_status=32'd4, md_reg=12 -> write to reg 30 with data 4; reg 12 untouched.
REQ-031 SHALL cover: wb_reg=0 and md_reg=0 requests -> ctrl_writeEnable stays 0; count unchanged.
REQ-032 SHALL cover: ctrl_reset with 2 entries buffered -> count=0, md_ready=1, no write issued; stall_cnt=0 (and increments only with WB_ARBITER_STALL_CNT_EN).
